alu_arbiter: RTL

Shares the single combinational 8-bit pico ALU between two requesters: port 0, the execute stage, and port 1, the address/PC helper. Arbitration is round-robin with a one-entry registered result stage and valid/ready backpressure. The block also holds the architectural status-flags register, which is updated only by granted operations that request it. It sits between the decode/execute control and the `alu` instance.

---
 rtl/pico_pkg.sv | 25 ++
 rtl/alu.sv | 56 +++++
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pico_pkg.sv
// ---------------------------------------------------------------------------
// pico_pkg
// Shared definitions for the pico datapath: operand width, ALU opcode
// encoding (F_*) and the bit positions of the four status flags inside the
// {Z,N,V,C} flag vector produced by the ALU.
// ---------------------------------------------------------------------------
package pico_pkg;

    localparam int N = 8;

    localparam logic [2:0] F_A   = 3'd0;
    localparam logic [2:0] F_ADD = 3'd1;
    localparam logic [2:0] F_SUB = 3'd2;
    localparam logic [2:0] F_MUL = 3'd3;
    localparam logic [2:0] F_AND = 3'd4;
    localparam logic [2:0] F_OR  = 3'd5;
    localparam logic [2:0] F_XOR = 3'd6;
    localparam logic [2:0] F_NOT = 3'd7;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational 8-bit pico ALU.
// Ports:
//   i_op    in  3  opcode (F_* encoding from pico_pkg)
//   i_a     in  N  operand a
//   i_b     in  N  operand b
//   o_res   out N  result
//   o_flags out 4  {Z,N,V,C}
// Z and N always come from the add/sub path; C and V are only driven for
// ADD and SUB and read as 0 otherwise. For SUB, C means "borrow".
// ---------------------------------------------------------------------------
module alu
    import pico_pkg::*;
(
    input  logic [2:0]   i_op,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_res,
    output logic [3:0]   o_flags
);

    logic         w_sub;
    logic         w_arith;
    logic [N-1:0] w_b_eff;
    logic [N:0]   w_sum;

    // Subtraction is a + ~b + 1 on the same adder.
    assign w_sub   = (i_op == F_SUB);
    assign w_arith = (i_op == F_ADD) || w_sub;
    assign w_b_eff = w_sub ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{N{1'b0}}, w_sub};

    always_comb begin
        // NOTE: default first so every path assigns o_res and no latch is inferred.
        o_res = w_sum[N-1:0];
        case (i_op)
            F_A:     o_res = i_a;
            F_MUL:   o_res = i_a * i_b;
            F_AND:   o_res = i_a & i_b;
            F_OR:    o_res = i_a | i_b;
            F_XOR:   o_res = i_a ^ i_b;
            F_NOT:   o_res = ~i_a;
            default: o_res = w_sum[N-1:0];
        endcase
    end

    assign o_flags[FLAG_Z] = (w_sum[N-1:0] == '0);
    assign o_flags[FLAG_N] = w_sum[N-1];
    // Overflow: operands agree in sign but the sum does not.
    assign o_flags[FLAG_V] = w_arith && (i_a[N-1] == w_b_eff[N-1])
                                     && (w_sum[N-1] != i_a[N-1]);
    // Carry out inverted for SUB to give a borrow flag.
    assign o_flags[FLAG_C] = w_arith && (w_sum[N] ^ w_sub);

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one pico ALU between port 0 (execute) and port 1 (address/PC
// helper). Round-robin grant, one-entry registered result stage with
// valid/ready backpressure, and the architectural flags register.
// Optional feature macro: ALU_ARB_LOCK_EN (port lock for multi-byte chains).
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_i[1:0]               per-port request (held until granted)
//   op0_i/op1_i, a*/b*       per-port opcode and operands
//   upd0_i/upd1_i            granted op loads flags_o
//   lock_i[1:0]              per-port lock (ignored unless ALU_ARB_LOCK_EN)
//   gnt_o[1:0]               one-hot combinational grant
//   res_valid_o/res_ready_i  result handshake
//   res_id_o, res_o          issuing port and held result
//   res_flags_o, flags_o     held result flags, architectural flags {Z,N,V,C}
// ---------------------------------------------------------------------------
module alu_arbiter
    import pico_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [1:0]   req_i,
    input  logic [2:0]   op0_i,
    input  logic [2:0]   op1_i,
    input  logic [N-1:0] a0_i,
    input  logic [N-1:0] b0_i,
    input  logic [N-1:0] a1_i,
    input  logic [N-1:0] b1_i,
    input  logic         upd0_i,
    input  logic         upd1_i,
    input  logic [1:0]   lock_i,
    output logic [1:0]   gnt_o,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic         res_id_o,
    output logic [N-1:0] res_o,
    output logic [3:0]   res_flags_o,
    output logic [3:0]   flags_o
);

    logic         r_res_valid;
    logic         r_res_id;
    logic [N-1:0] r_res;
    logic [3:0]   r_res_flags;
    logic [3:0]   r_flags;
    logic         r_last;

    logic         w_free;
    logic [1:0]   w_req_eff;
    logic [1:0]   w_gnt;
    logic         w_sel;
    logic         w_upd;
    logic [2:0]   w_op;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [N-1:0] w_alu_res;
    logic [3:0]   w_alu_flags;

    // The stage can take a new op if it is empty or draining this cycle.
    assign w_free = !r_res_valid || res_ready_i;

`ifdef ALU_ARB_LOCK_EN
    logic r_lock_active;
    logic r_lock_owner;

    // While locked, only the owner's request is visible, even when idle.
    assign w_req_eff = !r_lock_active ? req_i
                     : (r_lock_owner ? (req_i & 2'b10) : (req_i & 2'b01));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_lock_active <= 1'b0;
            r_lock_owner  <= 1'b0;
        end else if (|w_gnt) begin
            // Any grant sets or clears ownership from the granted port's lock bit.
            r_lock_active <= lock_i[w_sel];
            r_lock_owner  <= w_sel;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = ^lock_i;
    assign w_req_eff     = req_i;
`endif

    always_comb begin
        w_gnt = 2'b00;
        if (rst_ni && w_free) begin
            case (w_req_eff)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign gnt_o = w_gnt;
    assign w_sel = w_gnt[1];
    assign w_op  = w_sel ? op1_i  : op0_i;
    assign w_a   = w_sel ? a1_i   : a0_i;
    assign w_b   = w_sel ? b1_i   : b0_i;
    assign w_upd = w_sel ? upd1_i : upd0_i;

    alu u_alu (
        .i_op    (w_op),
        .i_a     (w_a),
        .i_b     (w_b),
        .o_res   (w_alu_res),
        .o_flags (w_alu_flags)
    );

    // NOTE: reset is synchronous here (sampled on the clock edge), not async.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res       <= '0;
            r_res_flags <= '0;
            r_flags     <= '0;
            r_last      <= 1'b1;
        end else if (|w_gnt) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_res_valid <= 1'b1;
            r_res_id    <= w_sel;
            r_res       <= w_alu_res;
            r_res_flags <= w_alu_flags;
            r_last      <= w_sel;
            if (w_upd) begin
                r_flags <= w_alu_flags;
            end
        end else if (res_ready_i) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid_o = r_res_valid;
    assign res_id_o    = r_res_id;
    assign res_o       = r_res;
    assign res_flags_o = r_res_flags;
    assign flags_o     = r_flags;

endmodule
